// File: rtl/scan_cmd_pkg.sv
// Shared command bytes, FSM state encoding and length width
// for the multi-chain scan command engine.
package scan_cmd_pkg;

  localparam int LEN_W = 16;

  localparam logic [7:0] RESET     = 8'h72;
  localparam logic [7:0] SET_STATE = 8'h73;
  localparam logic [7:0] GET_STATE = 8'h67;
  localparam logic [7:0] EXECUTE   = 8'h65;
  localparam logic [7:0] FREE_RUN  = 8'h66;
  localparam logic [7:0] PAUSE     = 8'h70;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_SET_WAIT,
    ST_SET_PULSE,
    ST_GET_WAITRDY,
    ST_GET_SEND,
    ST_GET_ACK,
    ST_GET_PULSE,
    ST_EXEC,
    ST_FREE,
    ST_RST
  } state_t;

endpackage

// File: rtl/part_clk_pulser.sv
// Single part-clock pulse: CLK_DIV cycles high then CLK_DIV low.
// Ports: clk, rst, start in; part_clk, busy, done (last low cycle) out.
module part_clk_pulser #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic part_clk,
  output logic busy,
  output logic done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          high_q;
  logic          busy_q;

  assign done     = busy_q && !high_q && (cnt_q == '0);
  assign busy     = busy_q;
  assign part_clk = high_q;

  // A start in the done cycle chains pulses back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (start && (!busy_q || done)) begin
      cnt_q  <= CW'(CLK_DIV - 1);
      high_q <= 1'b1;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else if (high_q) begin
        cnt_q  <= CW'(CLK_DIV - 1);
        high_q <= 1'b0;
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_cmd_engine.sv
// UART byte-command engine driving part clock/reset and NCHAINS scan chains.
// Ports: rx/tx byte stream, part_clk/part_rstn/test_se/test_tm/scan_in/out, idle, cmd_err.
module scan_cmd_engine #(
  parameter int NCHAINS    = 4,
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 8,
  parameter int FILL       = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               part_clk,
  output logic               part_rstn,
  output logic               test_se,
  output logic               test_tm,
  output logic [NCHAINS-1:0] scan_in,
  input  logic [NCHAINS-1:0] scan_out,
  output logic               idle,
  output logic               cmd_err
);

  import scan_cmd_pkg::*;

  localparam logic [NCHAINS-1:0] FILL_V  = NCHAINS'(FILL);
  localparam logic [LEN_W-1:0]   RST_LEN = LEN_W'(RST_CYCLES - 1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [NCHAINS-1:0] sin_q, sin_d;
  logic [7:0]         txd_q, txd_d;
  logic               err_q, err_d;
  logic               stop_q, stop_d;
  logic               rreq_q, rreq_d;
  logic               stop_now, rreq_now;
  logic               start, pbusy, pdone, pfree;

  part_clk_pulser #(.CLK_DIV(CLK_DIV)) u_pulser (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .part_clk (part_clk),
    .busy     (pbusy),
    .done     (pdone)
  );

  assign pfree = !pbusy || pdone;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    sin_d    = sin_q;
    txd_d    = txd_q;
    err_d    = err_q;
    stop_d   = stop_q;
    rreq_d   = rreq_q;
    stop_now = stop_q;
    rreq_now = rreq_q;
    start    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        rreq_d = 1'b0;
        if (rx_valid) begin
          cmd_d = rx_data;
          unique case (1'b1)
            (rx_data == SET_STATE) ||
            (rx_data == GET_STATE) ||
            (rx_data == EXECUTE):   state_d = ST_LEN_HI;
            (rx_data == FREE_RUN):  state_d = ST_FREE;
            (rx_data == RESET): begin
              state_d = ST_RST;
              cnt_d   = RST_LEN;
            end
            (rx_data == PAUSE): ;
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          cnt_d[15:8] = rx_data;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          cnt_d = {cnt_q[15:8], rx_data};
          if (cnt_d == '0)
            state_d = ST_IDLE;
          else if (cmd_q == SET_STATE)
            state_d = ST_SET_WAIT;
          else if (cmd_q == GET_STATE)
            state_d = ST_GET_WAITRDY;
          else
            state_d = ST_EXEC;
        end
      end
      ST_SET_WAIT: begin
        if (rx_valid) begin
          sin_d   = rx_data[NCHAINS-1:0];
          state_d = ST_SET_PULSE;
        end
      end
      ST_SET_PULSE: begin
        start = !pbusy;
        if (pdone) begin
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == 16'd1) ? ST_IDLE : ST_SET_WAIT;
        end
      end
      ST_GET_WAITRDY: begin
        if (tx_ready) begin
          txd_d                = '0;
          txd_d[NCHAINS-1:0]   = scan_out;
          state_d              = ST_GET_SEND;
        end
      end
      ST_GET_SEND: begin
        if (!tx_ready) state_d = ST_GET_ACK;
      end
      ST_GET_ACK: state_d = ST_GET_PULSE;
      ST_GET_PULSE: begin
        start = !pbusy;
        if (pdone) begin
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == 16'd1) ? ST_IDLE : ST_GET_WAITRDY;
        end
      end
      ST_EXEC: begin
        if (pfree) begin
          if (cnt_q != '0) begin
            start = 1'b1;
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FREE: begin
        if (rx_valid && (rx_data == PAUSE || rx_data == RESET))
          stop_now = 1'b1;
        if (rx_valid && rx_data == RESET)
          rreq_now = 1'b1;
        stop_d = stop_now;
        rreq_d = rreq_now;
        if (pfree) begin
          if (stop_now) begin
            state_d = rreq_now ? ST_RST : ST_IDLE;
            cnt_d   = RST_LEN;
          end else begin
            start = 1'b1;
          end
        end
      end
      ST_RST: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) txd_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      sin_q   <= '0;
      txd_q   <= '0;
      err_q   <= 1'b0;
      stop_q  <= 1'b0;
      rreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      sin_q   <= sin_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
      stop_q  <= stop_d;
      rreq_q  <= rreq_d;
    end
  end

  assign idle      = (state_q == ST_IDLE);
  assign tx_start  = (state_q == ST_GET_SEND);
  assign tx_data   = txd_q;
  assign part_rstn = (state_q != ST_RST);
  assign test_se   = (state_q == ST_SET_PULSE) || (state_q == ST_GET_PULSE);
  assign test_tm   = (state_q == ST_SET_WAIT) || (state_q == ST_SET_PULSE);
  assign cmd_err   = err_q;
  assign scan_in   = (state_q == ST_SET_PULSE) ? sin_q :
                     (state_q == ST_GET_PULSE) ? FILL_V : '0;

endmodule

// File: doc/scan_cmd_engine.md
Name: scan_cmd_engine

Overview:
- Parametrised command engine between the host UART byte stream (uart_rx/uart_tx) and a part under test with NCHAINS parallel scan chains.
- Decodes single-byte commands with 16-bit lengths.
- Generates the part clock, reset and scan controls.
- Returns captured scan data as bytes.
- Successor to the single-chain, ASCII-bit part-tester control path: multi-chain, configurable part-clock divider, reset pulse width, sticky error flag.

Parameters:
NCHAINS, 4, number of parallel scan chains (1..8); one chain bit per byte
CLK_DIV, 2, clk cycles part_clk stays high, and again low, per part-clock pulse (>=1)
RST_CYCLES, 8, clk cycles part_rstn held low on 'r'
FILL, 0, scan_in value shifted in during 'g'

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_valid  in  1  one-cycle strobe, rx_data valid (uart_rx rcv)
rx_data  in  8  received byte
tx_ready  in  1  uart_tx idle
tx_start  out  1  request transmit of tx_data
tx_data  out  8  byte to transmit
part_clk  out  1  part clock
part_rstn  out  1  part reset, active low
test_se  out  1  scan enable
test_tm  out  1  test mode
scan_in  out  NCHAINS  scan-chain inputs
scan_out  in  NCHAINS  scan-chain outputs
idle  out  1  high in IDLE
cmd_err  out  1  sticky, set on unknown command

Behaviour:
- Reset values, and values on entry to IDLE:
  - tx_start=0, tx_data=0, part_clk=0, part_rstn=1, test_se=0, test_tm=0, scan_in=0, idle=1.
  - cmd_err=0 is cleared only by rst or a completed 'r' command.
- Commands in IDLE:
  - 's' 0x73: shift in.
  - 'g' 0x67: shift out.
  - 'e' 0x65: execute.
  - 'f' 0x66: free run.
  - 'r' 0x72: reset part.
  - 'p' 0x70 in IDLE: ignored, no error.
  - Any other byte sets cmd_err and stays IDLE.
- Length: for 's'/'g'/'e', the next two rx bytes are LEN[15:8], then LEN[7:0]. States LEN_HI and LEN_LO.
  - LEN=0 returns to IDLE with no part_clk pulse and no tx byte.
- Pulse: part_clk high CLK_DIV cycles, then low CLK_DIV cycles. Caller resumes after the low phase.
- 's' (SET_WAIT -> SET_PULSE), per each of LEN rx bytes:
  - scan_in <= rx_data[NCHAINS-1:0] and test_se=1 on the cycle after rx_valid.
  - test_tm=1 for the whole command.
  - One pulse per byte.
  - Bytes arriving during a pulse are lost; the host paces one byte per UART frame.
- 'g' (GET_WAITRDY -> GET_SEND -> GET_ACK -> GET_PULSE), repeated LEN times:
  - Wait for tx_ready=1.
  - Sample scan_out into tx_data = {zero-pad, scan_out}.
  - Hold tx_start=1 until tx_ready falls, then deassert.
  - Pulse with test_se=1, scan_in=FILL.
  - The first byte is the pre-shift chain-tail value.
- 'e' (EXEC): LEN pulses with test_se=0, test_tm=0. rx ignored.
- 'f' (FREE): continuous pulses, test_se=0.
  - rx 'p' stops after the current pulse completes its low phase.
  - rx 'r' stops likewise, then performs a reset.
  - Other bytes are ignored.
- 'r' (RST): part_rstn=0 for exactly RST_CYCLES clk cycles, part_clk=0, then IDLE; clears cmd_err.
- Width rules:
  - Counters are 16-bit and count down from LEN.
  - LEN=0xFFFF yields 65535 pulses; no wrap.
- rst mid-operation: all outputs return to reset values on the next clk edge, and any in-flight pulse is truncated.
- Simultaneous tx_ready and state change: tx_start is asserted only in GET_SEND.

Decomposition:
- Package scan_cmd_pkg holds:
  - command byte localparams (RESET, SET_STATE, GET_STATE, EXECUTE, FREE_RUN, PAUSE);
  - the state encoding;
  - LEN width 16.
- One sub-module, part_clk_pulser: start in, busy/done out, CLK_DIV param.
  - Generates a single part_clk pulse; the FSM waits on done.

Test Plan:
1. rst=1 for 3 clk, release -> idle=1, part_rstn=1, test_se=0, tx_start=0, cmd_err=0.
2. NCHAINS=4, 's', 0x00, 0x03, bytes 0x0A,0x05,0x0F -> 3 part_clk pulses with scan_in 4'hA,4'h5,4'hF, test_se=1 at each rising edge; idle afterwards.
3. scan_out model: 4 shift registers of depth 3 preloaded. 'g', 0x00, 0x03 -> 3 tx bytes equal to chain tails before each shift (0x0A,0x05,0x0F after step 2); scan_in=0 during pulses.
4. 'e', 0x00, 0x05 -> exactly 5 part_clk pulses, each 2 clk high and 2 low, test_se=0; then 'e', 0x00, 0x00 -> zero pulses, immediate idle.
5. 'f', wait 40 clk, 'p' -> pulses stop with part_clk low, no partial pulse; idle=1. Then 'x' -> cmd_err=1.
6. 'r' -> part_rstn low exactly 8 clk, cmd_err cleared. Also: assert rst mid-'g' -> tx_start=0 and idle=1 on the next cycle.
